// File: rtl/vga_timing.sv
// Raster timing generator and display output stage for the VGA text path.
// Latency: newline leads first advance by LEAD clocks; pixel_in -> rgb and control decode -> syncs 1 clock.
// Backpressure: none; free-running raster, downstream pixeldata must keep up with advance.
//
// Ports:
//   clk       pixel clock (25 MHz for 640x480@60)
//   rst_n     asynchronous active-low reset
//   pixel_in  RGB444 from pixeldata.pixel
//   newline   one-clock pulse starting a line fetch in pixeldata
//   line      text-raster line for the fetch, valid with newline, held between pulses
//   advance   high during active pixels, steps the pixel shifter
//   frame     one-clock pulse at hcount=0, vcount=0
//   hsync_n   horizontal sync, active-low, aligned with rgb
//   vsync_n   vertical sync, active-low, aligned with rgb
//   rgb       blanked pixel to the DAC
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int LEAD     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] pixel_in,
    output logic        newline,
    output logic [7:0]  line,
    output logic        advance,
    output logic        frame,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic [11:0] rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef logic [9:0] cnt_t;

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
    localparam cnt_t H_NL     = cnt_t'(H_TOTAL - LEAD);
    localparam cnt_t H_RST    = cnt_t'(H_TOTAL - LEAD - 1);
    localparam cnt_t HS_BEG   = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VS_BEG   = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Raster counters
    cnt_t hcount;
    cnt_t vcount;

    // Next-counter values and the decodes taken from them. Decoding the
    // next values lets every control output be a flop while still being
    // true in the same cycle as the counter value it describes.
    cnt_t       hcount_nxt;
    cnt_t       vcount_nxt;
    cnt_t       vnext_nxt;
    logic       active_d;
    logic       newline_d;
    logic [7:0] line_d;
    logic       frame_d;
    logic       hs_d;
    logic       vs_d;

    // Control-stage sync decodes, one stage ahead of the pins
    logic       hs;
    logic       vs;

    function automatic cnt_t v_step(input cnt_t v);
        return (v == V_LAST) ? '0 : v + 10'd1;
    endfunction

    always_comb begin
        hcount_nxt = '0;
        vcount_nxt = vcount;
        if (hcount != H_LAST) begin
            hcount_nxt = hcount + 10'd1;
        end else begin
            vcount_nxt = v_step(vcount);
        end

        // Line the upcoming fetch is for: the line after the counter
        // value that will be current when newline is seen.
        vnext_nxt = v_step(vcount_nxt);

        active_d  = (hcount_nxt < H_ACT) && (vcount_nxt < V_ACT);
        newline_d = (hcount_nxt == H_NL) && (vnext_nxt < V_ACT);
        // Each text-raster line is shown on two scan lines
        line_d    = vnext_nxt[8:1];
        frame_d   = (hcount_nxt == '0) && (vcount_nxt == '0);
        hs_d      = (hcount_nxt >= HS_BEG) && (hcount_nxt <= HS_END);
        vs_d      = (vcount_nxt >= VS_BEG) && (vcount_nxt <= VS_END);
    end

    // Counters and control stage. Reset parks the raster LEAD+1 clocks
    // before the end of the last line so the first clock out of reset
    // issues the row-0 fetch and the frame starts LEAD clocks later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount  <= H_RST;
            vcount  <= V_LAST;
            newline <= 1'b0;
            line    <= '0;
            advance <= 1'b0;
            frame   <= 1'b0;
            hs      <= 1'b0;
            vs      <= 1'b0;
        end else begin
            hcount  <= hcount_nxt;
            vcount  <= vcount_nxt;
            newline <= newline_d;
            if (newline_d) begin
                line <= line_d;
            end
            advance <= active_d;
            frame   <= frame_d;
            hs      <= hs_d;
            vs      <= vs_d;
        end
    end

    // Display stage: pixeldata returns the pixel for the current advance
    // cycle, so blanking with advance and delaying the syncs by the same
    // one clock keeps rgb and sync edges aligned at the connector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            rgb     <= '0;
        end else begin
            hsync_n <= !hs;
            vsync_n <= !vs;
            rgb     <= advance ? pixel_in : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing on a reduced raster (48x15 clocks/lines, 720-clock frame).
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_timing;

    localparam int H_ACTIVE = 32;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 8;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int LEAD     = 4;

    logic        clk;
    logic        rst_n;
    logic [11:0] pixel_in;
    logic        newline;
    logic [7:0]  line;
    logic        advance;
    logic        frame;
    logic        hsync_n;
    logic        vsync_n;
    logic [11:0] rgb;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .LEAD     (LEAD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pixel_in (pixel_in),
        .newline  (newline),
        .line     (line),
        .advance  (advance),
        .frame    (frame),
        .hsync_n  (hsync_n),
        .vsync_n  (vsync_n),
        .rgb      (rgb)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [11:0] pix;
        logic        nl;
        logic [7:0]  ln;
        logic        adv;
        logic        fr;
        logic        hs_n;
        logic        vs_n;
        logic [11:0] rgb;
    } vec_t;

    localparam int NV = 23;

    vec_t vt [NV];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    function automatic logic [31:0] pack_o(input logic nl, input logic [7:0] ln,
                                           input logic adv, input logic fr,
                                           input logic hs_n, input logic vs_n,
                                           input logic [11:0] px);
        return {7'd0, nl, ln, adv, fr, hs_n, vs_n, px};
    endfunction

    function automatic logic [31:0] outs();
        return pack_o(newline, line, advance, frame, hsync_n, vsync_n, rgb);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int k);
        while (cyc < k) step();
    endtask

    logic [31:0] rst_o;
    logic        adv_prev;
    int          n_nl, n_adv, n_hs, n_vs, n_rgb_bad, n_fr, f1, f2;
    logic [63:0] lseq;

    initial begin
        // cyc, pix, newline, line, advance, frame, hsync_n, vsync_n, rgb
        // cycle k = k-th rising edge after reset release; k=5 is hcount=0,vcount=0
        vt[0]  = '{1,   12'hABC, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        vt[1]  = '{2,   12'hABC, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        vt[2]  = '{4,   12'hABC, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        vt[3]  = '{5,   12'hABC, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000};
        vt[4]  = '{6,   12'h123, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h123};
        vt[5]  = '{36,  12'hFFF, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 12'hFFF};
        vt[6]  = '{37,  12'h5A5, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h5A5};
        vt[7]  = '{38,  12'hFFF, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        vt[8]  = '{41,  12'hABC, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        vt[9]  = '{42,  12'hABC, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        vt[10] = '{49,  12'hABC, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        vt[11] = '{50,  12'hABC, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        vt[12] = '{97,  12'hABC, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        vt[13] = '{98,  12'hABC, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        vt[14] = '{337, 12'hABC, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        vt[15] = '{341, 12'hABC, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
        vt[16] = '{342, 12'h777, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1, 1'b1, 12'h777};
        vt[17] = '{385, 12'hABC, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        vt[18] = '{389, 12'hABC, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        vt[19] = '{485, 12'hABC, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        vt[20] = '{486, 12'hABC, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        vt[21] = '{581, 12'hABC, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        vt[22] = '{582, 12'hABC, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};

        rst_o    = pack_o(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        rst_n    = 1'b0;
        pixel_in = 12'hABC;

        // Clocks running under reset: everything held at reset values
        repeat (3) step();
        check("reset state", outs(), rst_o);

        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        for (int i = 0; i < NV; i++) begin
            step_to(vt[i].cyc - 1);
            pixel_in = vt[i].pix;
            step();
            check($sformatf("vec%0d@cyc%0d", i, vt[i].cyc), outs(),
                  pack_o(vt[i].nl, vt[i].ln, vt[i].adv, vt[i].fr,
                         vt[i].hs_n, vt[i].vs_n, vt[i].rgb));
        end

        // One full frame window (cycles 721..1440) starting at the row-0
        // fetch, plus 5 more clocks to see the next frame pulse.
        step_to(720);
        adv_prev  = advance;
        pixel_in  = 12'($urandom_range(4095, 1));
        n_nl = 0; n_adv = 0; n_hs = 0; n_vs = 0; n_rgb_bad = 0; n_fr = 0;
        f1 = 0; f2 = 0;
        lseq = '0;
        for (int i = 1; i <= 725; i++) begin
            step();
            if (rgb !== (adv_prev ? pixel_in : 12'h000)) n_rgb_bad++;
            if (i <= 720) begin
                if (newline) begin
                    n_nl++;
                    lseq = {lseq[55:0], line};
                end
                if (advance)  n_adv++;
                if (!hsync_n) n_hs++;
                if (!vsync_n) n_vs++;
            end
            if (frame) begin
                n_fr++;
                if (n_fr == 1) f1 = cyc;
                else           f2 = cyc;
            end
            adv_prev = advance;
            pixel_in = 12'($urandom_range(4095, 1));
        end
        check("frame pulses", 32'(n_fr), 32'd2);
        check("first frame cyc", 32'(f1), 32'd725);
        check("frame period", 32'(f2 - f1), 32'd720);
        check("newline count", 32'(n_nl), 32'd8);
        check("line seq hi", lseq[63:32], 32'h00000101);
        check("line seq lo", lseq[31:0], 32'h02020303);
        check("advance clocks", 32'(n_adv), 32'd256);
        check("hsync low clocks", 32'(n_hs), 32'd120);
        check("vsync low clocks", 32'(n_vs), 32'd96);
        check("rgb blanking", 32'(n_rgb_bad), 32'd0);

        // Mid-line reset in active video: hcount=20, vcount=3 of frame 3
        pixel_in = 12'hABC;
        step_to(1609);
        check("pre reset1", outs(), pack_o(1'b0, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1, 12'hABC));
        #5;
        rst_n = 1'b0;
        #1;
        check("async reset1", outs(), rst_o);
        repeat (3) step();
        check("held reset1", outs(), rst_o);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        step();
        check("restart1 newline", outs(), pack_o(1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000));
        step_to(5);
        check("restart1 frame", outs(), pack_o(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000));

        // Reset inside both sync pulses: hcount=40, vcount=10
        step_to(525);
        check("pre reset2", outs(), pack_o(1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000));
        #5;
        rst_n = 1'b0;
        #1;
        check("async reset2", outs(), rst_o);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        step();
        check("restart2 newline", outs(), pack_o(1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Raster timing generator and display output stage for the VGA text path. It runs horizontal and vertical counters for 640x480@60 at a 25 MHz pixel clock. It drives the control inputs of `pixeldata` (`newline`, `advance`, `line`) early enough to absorb that block's fetch latency. It registers `pixeldata`'s 12-bit pixel back in, blanks it, and aligns it with the sync outputs going to the DAC and connector.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal front porch / sync width / back porch, in clocks
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical front porch / sync width / back porch, in lines
- `LEAD`, 4: clocks between the `newline` pulse and the first active pixel of that line
- `clk`  in  1  pixel clock, 25 MHz
- `rst_n`  in  1  reset, asynchronous, active-low
- `pixel_in`  in  12  RGB444 from `pixeldata.pixel`
- `newline`  out  1  one-clock pulse that starts a line fetch
- `line`  out  8  text-raster line, valid when `newline`=1
- `advance`  out  1  high during active pixels; steps the pixel shifter
- `frame`  out  1  one-clock pulse at the start of each frame
- `hsync_n`  out  1  horizontal sync, active-low
- `vsync_n`  out  1  vertical sync, active-low
- `rgb`  out  12  blanked pixel to the DAC

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Counters: `hcount` is 10 bits, `vcount` is 10 bits.
  - `hcount` wraps H_TOTAL-1 -> 0.
  - `vcount` increments only when `hcount` wraps, and itself wraps V_TOTAL-1 -> 0.
- `vnext` = (`vcount`==V_TOTAL-1) ? 0 : `vcount`+1.
- The control stage decodes the current counters. All outputs are registered; implement them by decoding next-counter values so that the decodes below hold in the same cycle as the counter value.
  - `active` = (`hcount`<H_ACTIVE) && (`vcount`<V_ACTIVE).
  - `advance` = `active`.
  - `newline` = (`hcount`==H_TOTAL-LEAD) && (`vnext`<V_ACTIVE). Its `line` = `vnext`[8:1], range 0..239, giving vertical pixel doubling.
  - `line` holds its value between `newline` pulses.
  - `frame` = (`hcount`==0) && (`vcount`==0).
  - `hs` = `hcount` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
  - `vs` = `vcount` in [490, 491].
- The display stage is one register stage behind control:
  - `hsync_n` <= !`hs`
  - `vsync_n` <= !`vs`
  - `rgb` <= `active` ? `pixel_in` : 12'h000
- Why `newline` leads by LEAD=4: `pixeldata` spends 3 clocks in its wait states and loads character data on the 4th. `pixel_in` therefore shows pixel 0 in the cycle where `hcount`=0.
- No other state machine exists. The counters are the only state besides the output registers.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `hcount`=H_TOTAL-LEAD-1 (795), `vcount`=V_TOTAL-1 (524).
  - `newline`=0, `line`=0, `advance`=0, `frame`=0, `hsync_n`=1, `vsync_n`=1, `rgb`=0.
- First clock after release: `hcount`=796, `newline`=1, `line`=0.
  - This means row 0 of the first frame is fetched correctly.
  - `frame` pulses 4 clocks later, when `hcount`=0 and `vcount`=0.
- Latency and alignment:
  - `newline` to first `advance`: LEAD clocks.
  - `pixel_in` to `rgb`: 1 clock.
  - `hsync_n`/`vsync_n` lag their control decode by 1 clock, the same as `rgb`.
- Per frame:
  - `newline` fires exactly 480 times per frame.
  - Consecutive line pairs share `line` values (0,0,1,1,...,239,239).
  - No `newline` fires during vertical blanking, including `vnext`=480..524.
  - The `newline` for row 0 fires while `vcount`=524.
- `advance` is high for exactly 640 consecutive clocks per active line and 0 during blanking. The pixel data it clocks arrives as 16 clocks per character cell, 40 cells per line.
- Wrap boundaries:
  - When `hcount` 799->0 and `vcount` 524->0 occur together, the frame wraps.
  - `vcount` never reaches 525.
- Asserting reset mid-line returns to the reset values immediately. Outputs are forced inactive with no partial sync pulse extension.

## Test plan
- Reset release -> first cycle `newline`=1 with `line`=0; `frame` high 4 clocks later; `rgb`=0 throughout reset.
- Run one full frame -> 420000 clocks between `frame` pulses.
  - 480 `newline` pulses, with `line` sequence 0,0,1,...,239,239.
  - 307200 `advance`-high clocks.
- Horizontal sync -> `hsync_n` low for 96 clocks, starting 657 clocks after the `frame` pulse (656 plus the 1-clock stage). Vertical sync -> `vsync_n` low for exactly 1600 clocks (2 lines).
- Drive `pixel_in`=12'hABC constantly:
  - `rgb`=ABC for exactly 640 clocks per active line, starting 1 clock after `advance` rises.
  - `rgb`=000 in all blanking.
- Pair with `pixeldata`, chardata, and a VRAM/ROM model holding a known glyph -> pixel 0 of row 0 appears on `rgb` at the display-stage cycle for `hcount`=0. This checks that LEAD=4 alignment holds.
- Assert `rst_n` low mid-line at `hcount`=300, `vcount`=100, for 3 clocks:
  - Outputs go to reset values asynchronously.
  - After release, the sequence restarts at the reset-release behaviour.
